// File: rtl/inspector_pkg.sv
// Shared constants, state type and helpers for the serial packet inspector.
package inspector_pkg;

    typedef enum logic {
        HUNT    = 1'b0,
        PAYLOAD = 1'b1
    } state_e;

    localparam logic [31:0] SYNC_PATTERN = 32'hA5A5A5A5;

    // Payload bit positions are 1-based, counted after the sync pattern.
    localparam logic [8:0] PKT_BITS   = 9'd256;
    localparam logic [8:0] PORT_FIRST = 9'd65;
    localparam logic [8:0] PORT_LAST  = 9'd80;
    localparam logic [8:0] SESS_FIRST = 9'd137;
    localparam logic [8:0] SESS_LAST  = 9'd144;

    localparam logic [15:0] PORT_FTP    = 16'd21;
    localparam logic [15:0] PORT_SSH    = 16'd22;
    localparam logic [15:0] PORT_TELNET = 16'd23;
    localparam logic [15:0] PORT_SMTP   = 16'd25;
    localparam logic [15:0] PORT_NNTP   = 16'd119;
    localparam logic [15:0] PORT_SNMP   = 16'd161;
    localparam logic [15:0] PORT_HTTPS  = 16'd443;
    localparam logic [15:0] PORT_SKYPE  = 16'd23399;

    localparam int NUM_PROTO = 8;
    localparam int P_SKYPE  = 0;
    localparam int P_FTP    = 1;
    localparam int P_HTTPS  = 2;
    localparam int P_TELNET = 3;
    localparam int P_SSH    = 4;
    localparam int P_SNMP   = 5;
    localparam int P_SMTP   = 6;
    localparam int P_NNTP   = 7;

    // One-hot protocol hit vector; all zeros for an unknown port.
    function automatic logic [NUM_PROTO-1:0] classify(input logic [15:0] port);
        logic [NUM_PROTO-1:0] hit;
        hit = '0;
        case (port)
            PORT_SKYPE:  hit[P_SKYPE]  = 1'b1;
            PORT_FTP:    hit[P_FTP]    = 1'b1;
            PORT_HTTPS:  hit[P_HTTPS]  = 1'b1;
            PORT_TELNET: hit[P_TELNET] = 1'b1;
            PORT_SSH:    hit[P_SSH]    = 1'b1;
            PORT_SNMP:   hit[P_SNMP]   = 1'b1;
            PORT_SMTP:   hit[P_SMTP]   = 1'b1;
            PORT_NNTP:   hit[P_NNTP]   = 1'b1;
            default:     hit = '0;
        endcase
        return hit;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/inspector_sync_detector.sv
// 32-bit serial shift register that flags the sync pattern, including the
// bit arriving this cycle. Clear empties the window for a fresh search.
module sync_detector
    import inspector_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic data_i,
    input  logic clear_i,
    output logic match_o
);

    logic [31:0] sr_q, sr_d;
    logic [31:0] shifted;

    assign shifted = {sr_q[30:0], data_i};
    // An X/Z bit makes the compare unknown, which never counts as a match.
    assign match_o = (shifted == SYNC_PATTERN);

    always_comb begin
        sr_d = clear_i ? '0 : shifted;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

endmodule

// File: rtl/inspector.sv
// Serial packet inspector: locks on the sync pattern, parses a 256-bit packet
// and keeps per-protocol counters. Session capture is built only when
// INSPECTOR_SESSION_EN is defined; otherwise the *_session outputs are 0.
module inspector
    import inspector_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        data,
    output logic [31:0] total_cnt,
    output logic [7:0]  skype_cnt,
    output logic [7:0]  ftp_cnt,
    output logic [7:0]  https_cnt,
    output logic [7:0]  telnet_cnt,
    output logic [7:0]  ssh_cnt,
    output logic [7:0]  snmp_cnt,
    output logic [7:0]  smtp_cnt,
    output logic [7:0]  nntp_cnt,
    output logic [7:0]  telnet_session,
    output logic [7:0]  skype_session,
    output logic [7:0]  ssh_session
);

    state_e                state_q, state_d;
    logic [7:0]            bit_cnt_q, bit_cnt_d;
    logic [8:0]            bit_num;
    logic [15:0]           port_q, port_d;
    logic [31:0]           total_q, total_d;
    logic [7:0]            cnt_q [NUM_PROTO];
    logic [7:0]            cnt_d [NUM_PROTO];
    logic [NUM_PROTO-1:0]  hit;
    logic                  match;
    logic                  in_port;
    logic                  pkt_done;

    // The window is held empty during the payload, so after a packet the
    // next lock needs 32 fresh pattern bits.
    sync_detector u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .data_i  (data),
        .clear_i ((state_q == PAYLOAD) || match),
        .match_o (match)
    );

    assign bit_num = {1'b0, bit_cnt_q} + 9'd1;
    assign in_port = (bit_num >= PORT_FIRST) && (bit_num <= PORT_LAST);

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        port_d    = port_q;
        pkt_done  = 1'b0;
        case (state_q)
            HUNT: begin
                if (match) begin
                    state_d   = PAYLOAD;
                    bit_cnt_d = '0;
                end
            end
            PAYLOAD: begin
                bit_cnt_d = bit_cnt_q + 8'd1;
                if (in_port) begin
                    port_d = {port_q[14:0], data};
                end
                if (bit_num == PKT_BITS) begin
                    pkt_done  = 1'b1;
                    state_d   = HUNT;
                    bit_cnt_d = '0;
                end
            end
            default: state_d = HUNT;
        endcase
    end

    // Port is complete long before bit 256, so the registered value is used.
    assign hit = classify(port_q);

    always_comb begin
        total_d = pkt_done ? total_q + 32'd1 : total_q;
        for (int i = 0; i < NUM_PROTO; i++) begin
            cnt_d[i] = (pkt_done && hit[i]) ? sat_inc8(cnt_q[i]) : cnt_q[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= HUNT;
            bit_cnt_q <= '0;
            port_q    <= '0;
            total_q   <= '0;
            for (int i = 0; i < NUM_PROTO; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            port_q    <= port_d;
            total_q   <= total_d;
            for (int i = 0; i < NUM_PROTO; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign total_cnt  = total_q;
    assign skype_cnt  = cnt_q[P_SKYPE];
    assign ftp_cnt    = cnt_q[P_FTP];
    assign https_cnt  = cnt_q[P_HTTPS];
    assign telnet_cnt = cnt_q[P_TELNET];
    assign ssh_cnt    = cnt_q[P_SSH];
    assign snmp_cnt   = cnt_q[P_SNMP];
    assign smtp_cnt   = cnt_q[P_SMTP];
    assign nntp_cnt   = cnt_q[P_NNTP];

`ifdef INSPECTOR_SESSION_EN
    logic [7:0] sess_q, sess_d;
    logic [7:0] telnet_sess_q, telnet_sess_d;
    logic [7:0] skype_sess_q, skype_sess_d;
    logic [7:0] ssh_sess_q, ssh_sess_d;
    logic       in_sess;

    assign in_sess = (state_q == PAYLOAD) &&
                     (bit_num >= SESS_FIRST) && (bit_num <= SESS_LAST);

    always_comb begin
        sess_d        = in_sess ? {sess_q[6:0], data} : sess_q;
        telnet_sess_d = telnet_sess_q;
        skype_sess_d  = skype_sess_q;
        ssh_sess_d    = ssh_sess_q;
        if (pkt_done) begin
            if (hit[P_TELNET]) telnet_sess_d = sess_q;
            if (hit[P_SKYPE])  skype_sess_d  = sess_q;
            if (hit[P_SSH])    ssh_sess_d    = sess_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sess_q        <= '0;
            telnet_sess_q <= '0;
            skype_sess_q  <= '0;
            ssh_sess_q    <= '0;
        end else begin
            sess_q        <= sess_d;
            telnet_sess_q <= telnet_sess_d;
            skype_sess_q  <= skype_sess_d;
            ssh_sess_q    <= ssh_sess_d;
        end
    end

    assign telnet_session = telnet_sess_q;
    assign skype_session  = skype_sess_q;
    assign ssh_session    = ssh_sess_q;
`else
    assign telnet_session = '0;
    assign skype_session  = '0;
    assign ssh_session    = '0;
`endif

endmodule

// File: tb/tb_inspector.sv
// Randomized and directed bench for the inspector; expected values come from
// a list of the packets fully sent since the last reset.
module tb_inspector;

`ifdef INSPECTOR_SESSION_EN
    localparam bit SESS_EN = 1'b1;
`else
    localparam bit SESS_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        data;
    logic [31:0] total_cnt;
    logic [7:0]  skype_cnt, ftp_cnt, https_cnt, telnet_cnt;
    logic [7:0]  ssh_cnt, snmp_cnt, smtp_cnt, nntp_cnt;
    logic [7:0]  telnet_session, skype_session, ssh_session;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] port;
        logic [7:0]  sess;
    } pkt_t;
    pkt_t pkts[$];

    inspector dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .data           (data),
        .total_cnt      (total_cnt),
        .skype_cnt      (skype_cnt),
        .ftp_cnt        (ftp_cnt),
        .https_cnt      (https_cnt),
        .telnet_cnt     (telnet_cnt),
        .ssh_cnt        (ssh_cnt),
        .snmp_cnt       (snmp_cnt),
        .smtp_cnt       (smtp_cnt),
        .nntp_cnt       (nntp_cnt),
        .telnet_session (telnet_session),
        .skype_session  (skype_session),
        .ssh_session    (ssh_session)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", name, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_cnt(input logic [15:0] p);
        int n = 0;
        foreach (pkts[i]) if (pkts[i].port == p) n++;
        return (n > 255) ? 32'd255 : 32'(n);
    endfunction

    function automatic logic [31:0] exp_sess(input logic [15:0] p);
        logic [31:0] s = 0;
        foreach (pkts[i]) if (pkts[i].port == p) s = 32'(pkts[i].sess);
        return SESS_EN ? s : 32'd0;
    endfunction

    task automatic check_all(input string tag);
        chk({tag, " total"},  total_cnt,  32'(pkts.size()));
        chk({tag, " skype"},  skype_cnt,  exp_cnt(16'd23399));
        chk({tag, " ftp"},    ftp_cnt,    exp_cnt(16'd21));
        chk({tag, " https"},  https_cnt,  exp_cnt(16'd443));
        chk({tag, " telnet"}, telnet_cnt, exp_cnt(16'd23));
        chk({tag, " ssh"},    ssh_cnt,    exp_cnt(16'd22));
        chk({tag, " snmp"},   snmp_cnt,   exp_cnt(16'd161));
        chk({tag, " smtp"},   smtp_cnt,   exp_cnt(16'd25));
        chk({tag, " nntp"},   nntp_cnt,   exp_cnt(16'd119));
        chk({tag, " telnet_sess"}, telnet_session, exp_sess(16'd23));
        chk({tag, " skype_sess"},  skype_session,  exp_sess(16'd23399));
        chk({tag, " ssh_sess"},    ssh_session,    exp_sess(16'd22));
    endtask

    // Input changes 1 time unit after the edge; outputs are read at that point.
    task automatic send_bit(input logic b);
        data = b;
        @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        data  = 1'b0;
        pkts.delete();
        repeat (3) @(posedge clk);
        #1;
        check_all("reset");
        rst_n = 1'b1;
    endtask

    // Payload bit n (1-based, MSB first) is pl[256-n].
    task automatic send_pkt(input logic [15:0] port, input logic [7:0] sess,
                            input logic [31:0] noise, input int nlen,
                            input bit sync_in_pl, input string tag);
        logic [255:0] pl;
        pkt_t p;
        for (int w = 0; w < 8; w++) pl[w*32 +: 32] = $urandom;
        pl[191:176] = port;
        pl[119:112] = sess;
        if (sync_in_pl) pl[255:224] = 32'hA5A5A5A5;
        send_bits(noise, nlen);
        send_bits(32'hA5A5A5A5, 32);
        for (int i = 255; i >= 1; i--) send_bit(pl[i]);
        chk({tag, " pre_done total"}, total_cnt, 32'(pkts.size()));
        send_bit(pl[0]);
        p.port = port;
        p.sess = sess;
        pkts.push_back(p);
        check_all(tag);
    endtask

    initial begin
        logic [15:0] ports [12];
        logic [31:0] nz;
        int          nl;
        ports = '{16'd21, 16'd22, 16'd23, 16'd25, 16'd119, 16'd161, 16'd443,
                  16'd23399, 16'd80, 16'd8080, 16'd0, 16'd65535};

        do_reset();

        // Single SSH packet behind one noise bit.
        send_pkt(16'd22, 8'd7, 32'h0, 1, 1'b0, "ssh");
        chk("plan ssh_cnt", ssh_cnt, 32'd1);
        chk("plan ssh_sess", ssh_session, SESS_EN ? 32'd7 : 32'd0);

        // Back-to-back Telnet, Skype, FTP.
        do_reset();
        send_pkt(16'd23, 8'd3, 32'h0, 0, 1'b0, "b2b telnet");
        send_pkt(16'd23399, 8'd9, 32'h0, 0, 1'b0, "b2b skype");
        send_pkt(16'd21, 8'd0, 32'h0, 0, 1'b0, "b2b ftp");
        chk("plan b2b total", total_cnt, 32'd3);

        // False partial pattern, then an unknown port.
        do_reset();
        send_pkt(16'd80, 8'd55, 32'hA5A5A500, 32, 1'b0, "unknown");

        // Sync pattern inside the payload must not re-lock.
        do_reset();
        send_pkt(16'd25, 8'd1, 32'h0, 1, 1'b1, "smtp sync_in_pl");
        repeat (40) send_bit(1'b0);
        check_all("smtp idle");

        // Reset at payload bit 100 aborts the packet.
        send_bits(32'hA5A5A5A5, 32);
        repeat (99) send_bit(1'b1);
        rst_n = 1'b0;
        pkts.delete();
        #2;
        check_all("mid_reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send_pkt(16'd443, 8'd4, 32'h0, 0, 1'b0, "https after reset");

        // Randomized packets with short noise gaps ending in 0.
        for (int k = 0; k < 16; k++) begin
            nl = $urandom_range(0, 7);
            nz = $urandom & 32'hFFFF_FFFE;
            send_pkt(ports[$urandom_range(0, 11)], 8'($urandom), nz, nl, 1'b0, "rand");
        end

        // Saturation of a protocol counter.
        do_reset();
        for (int k = 0; k < 260; k++) send_pkt(16'd161, 8'($urandom), 32'h0, 0, 1'b0, "snmp sat");
        chk("plan snmp sat", snmp_cnt, 32'd255);
        chk("plan snmp total", total_cnt, 32'd260);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
